// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2R1W register file.
// Clear-sequencer state encoding lives here so sub-blocks agree on it.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks an index over every entry, one per cycle,
// and gates writes off while the walk is in progress.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          wr_gate_o,
    output logic [AW-1:0] idx_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and index registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: terminal compare against LAST, index never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy_o    = (state_q == CLEAR);
    assign done_o    = (state_q == DONE);
    assign wr_gate_o = (state_q != CLEAR);
    assign idx_o     = idx_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two registered read ports, one write port, with write/clear bypass
// and a hardware clear sequencer.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             We,
    input  logic [AW-1:0]    Waddr,
    input  logic [WIDTH-1:0] Wdata,
    input  logic [AW-1:0]    Raddr_a,
    output logic [WIDTH-1:0] Rdata_a,
    input  logic [AW-1:0]    Raddr_b,
    output logic [WIDTH-1:0] Rdata_b,
    input  logic             Clr_req,
    output logic             Busy,
    output logic             Clr_done,
    output logic             Wr_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    logic             wr_err_q;

    logic             busy;
    logic             wr_gate;
    logic [AW-1:0]    clr_idx;
    logic             wa_ok;
    logic             wr_acc;
    logic             wr_drop;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .clr_req_i (Clr_req),
        .busy_o    (busy),
        .done_o    (Clr_done),
        .wr_gate_o (wr_gate),
        .idx_o     (clr_idx)
    );

    assign wa_ok   = ((AW+1)'(Waddr) < (AW+1)'(DEPTH));
    assign wr_acc  = We && wa_ok && wr_gate;
    assign wr_drop = We && !(wa_ok && wr_gate);

    // Next array contents; clear and write are mutually exclusive.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (busy && clr_idx == AW'(i)) begin
                mem_d[i] = '0;
            end else if (wr_acc && Waddr == AW'(i)) begin
                mem_d[i] = Wdata;
            end
        end
    end

    // Read from next-state array so writes and clears bypass.
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Raddr_a == AW'(i)) rd_a_d = mem_d[i];
            if (Raddr_b == AW'(i)) rd_b_d = mem_d[i];
        end
    end

    // Storage, read registers and dropped-write flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            wr_err_q <= wr_drop;
        end
    end

    assign Rdata_a = rd_a_q;
    assign Rdata_b = rd_b_q;
    assign Busy    = busy;
    assign Wr_err  = wr_err_q;

endmodule
